extmem_initiator: RTL and testbench

Initiator-side controller for one external memory bank port. Accepts read/write commands from a client over a valid/ready stream, buffers them, and drives the bank's request/grant and command bus (req, ce, w, a, tag, d, be). It tracks tags of outstanding reads and returns read data to the client with the tag attached. Sits between a client (e.g. a DMA or compute engine) and a memory bank or its behavioural model.

---
 rtl/extmem_pkg.sv | 25 ++
 rtl/extmem_initiator_if.sv | 59 +++++
 rtl/extmem_initiator_sync_fifo.sv | 59 +++++
 rtl/extmem_initiator.sv | 106 ++++++++++
 tb/tb_extmem_initiator.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/extmem_pkg.sv
// Shared widths, command record and small enums for the external-memory initiator.
package extmem_pkg;

  localparam int unsigned CMD_DEPTH_DEF     = 4;
  localparam int unsigned DATA_WIDTH_DEF    = 128;
  localparam int unsigned TAG_WIDTH_DEF     = 2;
  localparam int unsigned ADDRESS_WIDTH_DEF = 32;
  localparam int unsigned BE_WIDTH_DEF      = DATA_WIDTH_DEF / 8;
  localparam int unsigned TAG_COUNT         = 1 << TAG_WIDTH_DEF;

  typedef struct packed {
    logic                         w;
    logic [ADDRESS_WIDTH_DEF-1:0] a;
    logic [DATA_WIDTH_DEF-1:0]    d;
    logic [BE_WIDTH_DEF-1:0]      be;
  } cmd_t;

  // Cycles left in which a stray bank response is dropped without flagging err.
  typedef enum logic [1:0] {
    DRAIN_OFF = 2'd0,
    DRAIN_ONE = 2'd1,
    DRAIN_TWO = 2'd2
  } drain_e;

endpackage

// File: rtl/extmem_initiator_if.sv
// Client command/response stream and bank command bus, each with master/slave views.
interface extmem_cmd_if
  import extmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned TAG_WIDTH     = TAG_WIDTH_DEF,
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned BE_WIDTH      = BE_WIDTH_DEF
) ();
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic                     cmd_w;
  logic [ADDRESS_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0]    cmd_d;
  logic [BE_WIDTH-1:0]      cmd_be;
  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic [TAG_WIDTH-1:0]     rsp_tag;
  logic                     err;

  modport master (
    output cmd_valid, cmd_w, cmd_a, cmd_d, cmd_be,
    input  cmd_ready, rsp_valid, rsp_data, rsp_tag, err
  );
  modport slave (
    input  cmd_valid, cmd_w, cmd_a, cmd_d, cmd_be,
    output cmd_ready, rsp_valid, rsp_data, rsp_tag, err
  );
endinterface

interface extmem_bank_if
  import extmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned TAG_WIDTH     = TAG_WIDTH_DEF,
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned BE_WIDTH      = BE_WIDTH_DEF
) ();
  logic                     req;
  logic                     ready;
  logic                     ce;
  logic                     w;
  logic [ADDRESS_WIDTH-1:0] a;
  logic [TAG_WIDTH-1:0]     tag;
  logic [DATA_WIDTH-1:0]    d;
  logic [BE_WIDTH-1:0]      be;
  logic                     valid;
  logic [DATA_WIDTH-1:0]    q;
  logic [TAG_WIDTH-1:0]     qtag;

  modport master (
    output req, ce, w, a, tag, d, be,
    input  ready, valid, q, qtag
  );
  modport slave (
    input  req, ce, w, a, tag, d, be,
    output ready, valid, q, qtag
  );
endinterface

// File: rtl/extmem_initiator_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags; head is visible combinationally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

// File: rtl/extmem_initiator.sv
// Buffers client commands, issues them to one memory bank port and returns tagged read data.
module extmem_initiator
  import extmem_pkg::*;
#(
  parameter int unsigned CMD_DEPTH     = CMD_DEPTH_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned TAG_WIDTH     = TAG_WIDTH_DEF,
  parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int unsigned BE_WIDTH      = BE_WIDTH_DEF
) (
  input logic           clk,
  input logic           rst,
  extmem_cmd_if.slave   client,
  extmem_bank_if.master bank
);
  localparam int unsigned CMD_W = 1 + ADDRESS_WIDTH + DATA_WIDTH + BE_WIDTH;
  localparam int unsigned TAGS  = 1 << TAG_WIDTH;

  logic [CMD_W-1:0]         head;
  logic                     head_w;
  logic [ADDRESS_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0]    head_d;
  logic [BE_WIDTH-1:0]      head_be;
  logic                     cmd_full, cmd_empty, cmd_push;
  logic [TAG_WIDTH-1:0]     exp_tag;
  logic                     tag_full, tag_empty;
  logic                     issue, rsp_take, tag_mismatch, unexpected;

  logic [TAG_WIDTH-1:0]     tag_q;
  logic                     rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_data_q;
  logic [TAG_WIDTH-1:0]     rsp_tag_q;
  logic                     err_q;
  drain_e                   drain_q;

  assign cmd_push = client.cmd_valid & ~cmd_full;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (cmd_push),
    .wdata_i ({client.cmd_w, client.cmd_a, client.cmd_d, client.cmd_be}),
    .pop_i   (issue),
    .rdata_o (head),
    .full_o  (cmd_full),
    .empty_o (cmd_empty)
  );

  assign {head_w, head_a, head_d, head_be} = head;

  // A read may only leave once a slot in the expected-tag FIFO is guaranteed.
  assign issue = bank.ready & ~cmd_empty & ~(~head_w & tag_full) & ~rst;

  sync_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(TAGS)) u_tag_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (issue & ~head_w),
    .wdata_i (tag_q),
    .pop_i   (rsp_take),
    .rdata_o (exp_tag),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  assign rsp_take     = bank.valid & ~tag_empty;
  assign tag_mismatch = rsp_take & (bank.qtag != exp_tag);
  assign unexpected   = bank.valid & tag_empty & (drain_q == DRAIN_OFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      err_q       <= 1'b0;
      drain_q     <= DRAIN_TWO;
    end else begin
      if (issue) tag_q <= tag_q + TAG_WIDTH'(1);
      rsp_valid_q <= rsp_take;
      if (rsp_take) begin
        rsp_data_q <= bank.q;
        rsp_tag_q  <= bank.qtag;
      end
      if (tag_mismatch | unexpected) err_q <= 1'b1;
      unique case (drain_q)
        DRAIN_TWO: drain_q <= DRAIN_ONE;
        DRAIN_ONE: drain_q <= DRAIN_OFF;
        default:   drain_q <= DRAIN_OFF;
      endcase
    end
  end

  assign client.cmd_ready = ~cmd_full;
  assign client.rsp_valid = rsp_valid_q;
  assign client.rsp_data  = rsp_data_q;
  assign client.rsp_tag   = rsp_tag_q;
  assign client.err       = err_q;

  assign bank.req = ~cmd_empty;
  assign bank.ce  = issue;
  assign bank.w   = head_w;
  assign bank.a   = head_a;
  assign bank.d   = head_d;
  assign bank.be  = head_be;
  assign bank.tag = tag_q;
endmodule

// File: tb/tb_extmem_initiator.sv
// Directed bench with a bank model and a queue-level reference model of the initiator.
module tb_extmem_initiator;
  import extmem_pkg::*;

  localparam int unsigned DW = 128, AW = 32, BW = 16, TW = 2, DEPTH = 4, NTAGS = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  extmem_cmd_if  #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .ADDRESS_WIDTH(AW), .BE_WIDTH(BW)) cif ();
  extmem_bank_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .ADDRESS_WIDTH(AW), .BE_WIDTH(BW)) bif ();

  extmem_initiator #(
    .CMD_DEPTH(DEPTH), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .ADDRESS_WIDTH(AW), .BE_WIDTH(BW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .client (cif.slave),
    .bank   (bif.master)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [127:0] init_word(input int unsigned i);
    logic [31:0] x;
    x = 32'h1000_0000 + i;
    return {4{x}};
  endfunction

  // ---------------- bank model ----------------
  typedef struct {
    int          due;
    logic [127:0] data;
    logic [1:0]  tag;
  } bresp_t;

  logic [127:0] mem [256];
  bresp_t       pend [$];
  logic [1:0]   issued_tags [$];
  int           issued_cyc [$];
  int  cyc = 0;
  int  lat = 1;
  bit  gnt_en = 0, pulse_mode = 0, bad_tag_next = 0, spurious_next = 0;
  logic req_s = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    bif.ready = 1'b0; bif.valid = 1'b0; bif.q = '0; bif.qtag = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bif.ready = gnt_en & req_s & !(pulse_mode && (cyc % 33) < 2);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bresp_t r;
        r = pend.pop_front();
        bif.valid = 1'b1; bif.q = r.data; bif.qtag = r.tag;
      end else if (spurious_next) begin
        spurious_next = 0;
        bif.valid = 1'b1; bif.q = 128'hDEAD; bif.qtag = 2'd0;
      end else begin
        bif.valid = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    req_s = bif.req;
    if (bif.ce === 1'b1) begin
      issued_tags.push_back(bif.tag);
      issued_cyc.push_back(cyc);
      if (bif.w) begin
        for (int b = 0; b < 16; b++)
          if (bif.be[b]) mem[bif.a[7:0]][8*b +: 8] = bif.d[8*b +: 8];
      end else begin
        bresp_t r;
        r.due = cyc + lat; r.data = mem[bif.a[7:0]]; r.tag = bif.tag;
        if (bad_tag_next) begin r.tag = 2'd3; bad_tag_next = 0; end
        pend.push_back(r);
      end
    end
  end

  // ---------------- response log ----------------
  typedef struct {
    logic [127:0] d;
    logic [1:0]   t;
  } rlog_t;
  rlog_t rsp_log [$];

  initial forever begin
    @(negedge clk);
    if (cif.rsp_valid === 1'b1) begin
      rlog_t e;
      e.d = cif.rsp_data; e.t = cif.rsp_tag;
      rsp_log.push_back(e);
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  cmd_t       mq   [$];
  logic [1:0] mexp [$];
  logic [1:0] mtag = '0;
  bit         mrv = 0, merr = 0, minit = 0;
  logic [127:0] mrd = '0;
  logic [1:0] mrt = '0;
  int         mdrain = 0;

  initial forever begin
    bit ce_e;
    @(negedge clk);
    ce_e = (bif.ready === 1'b1) && mq.size() > 0 && !(!mq[0].w && mexp.size() == NTAGS) && !rst;
    if (minit) begin
      chk("cmd_ready", cif.cmd_ready, mq.size() < DEPTH);
      chk("req", bif.req, mq.size() > 0);
      chk("ce", bif.ce, ce_e);
      chk("rsp_valid", cif.rsp_valid, mrv);
      chk("rsp_data", cif.rsp_data, mrd);
      chk("rsp_tag", cif.rsp_tag, mrt);
      chk("err", cif.err, merr);
      if (ce_e) begin
        chk("bank_w", bif.w, mq[0].w);
        chk("bank_a", bif.a, mq[0].a);
        chk("bank_d", bif.d, mq[0].d);
        chk("bank_be", bif.be, mq[0].be);
        chk("bank_tag", bif.tag, mtag);
      end
    end
    if (rst) begin
      mq.delete(); mexp.delete();
      mtag = '0; mrv = 0; mrd = '0; mrt = '0; merr = 0; mdrain = 2; minit = 1;
    end else if (minit) begin
      bit acc;
      acc = cif.cmd_valid && mq.size() < DEPTH;
      mrv = 0;
      if (bif.valid) begin
        if (mexp.size() > 0) begin
          logic [1:0] e;
          e = mexp.pop_front();
          mrv = 1; mrd = bif.q; mrt = bif.qtag;
          if (bif.qtag != e) merr = 1;
        end else if (mdrain == 0) begin
          merr = 1;
        end
      end
      if (ce_e) begin
        cmd_t c;
        c = mq.pop_front();
        if (!c.w) mexp.push_back(mtag);
        mtag = mtag + 2'd1;
      end
      if (acc) begin
        cmd_t c;
        c.w = cif.cmd_w; c.a = cif.cmd_a; c.d = cif.cmd_d; c.be = cif.cmd_be;
        mq.push_back(c);
      end
      if (mdrain > 0) mdrain--;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push_cmd(input logic w, input logic [31:0] a, input logic [127:0] d,
                          input logic [15:0] be, output int waits);
    bit rdy;
    rdy = 0; waits = 0;
    cif.cmd_w = w; cif.cmd_a = a; cif.cmd_d = d; cif.cmd_be = be;
    cif.cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = cif.cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
    end
    cif.cmd_valid = 1'b0;
    if (!rdy) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input string name, output logic [127:0] d, output logic [1:0] t);
    bit got;
    got = 0; d = '0; t = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cif.rsp_valid === 1'b1) begin
        d = cif.rsp_data; t = cif.rsp_tag; got = 1;
        break;
      end
    end
    if (!got) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int w;
    logic [127:0] d;
    logic [1:0]   t;
    cif.cmd_valid = 1'b0; cif.cmd_w = 1'b0; cif.cmd_a = '0; cif.cmd_d = '0; cif.cmd_be = '0;
    @(posedge clk); #1;
    do_reset(2);

    @(negedge clk);
    chk("rst_cmd_ready", cif.cmd_ready, 1);
    chk("rst_req", bif.req, 0);
    chk("rst_ce", bif.ce, 0);
    chk("rst_rsp_valid", cif.rsp_valid, 0);
    chk("rst_err", cif.err, 0);
    @(posedge clk); #1;

    // single read, bank grants in response to req
    gnt_en = 1;
    push_cmd(1'b0, 32'd5, '0, '0, w);
    chk("s1_accept_wait", w, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("s1_rsp_valid_c%0d", k), cif.rsp_valid, k == 4);
    end
    chk("s1_rsp_data", cif.rsp_data, 128'h10000005_10000005_10000005_10000005);
    chk("s1_rsp_tag", cif.rsp_tag, 0);
    chk("s1_err", cif.err, 0);
    @(posedge clk); #1;

    // six writes against a withheld grant
    do_reset(1);
    gnt_en = 0;
    issued_tags.delete(); issued_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      push_cmd(1'b1, 32'd20 + i, {4{32'hA000_0000 + i}}, '1, w);
      chk($sformatf("s2_accept_wait_%0d", i), w, 0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("s2_cmd_ready_full", cif.cmd_ready, 0);
      chk("s2_ce_no_grant", bif.ce, 0);
      chk("s2_req_held", bif.req, 1);
    end
    @(posedge clk); #1;
    gnt_en = 1;
    push_cmd(1'b1, 32'd24, {4{32'hA000_0004}}, '1, w);
    push_cmd(1'b1, 32'd25, {4{32'hA000_0005}}, '1, w);
    repeat (8) @(posedge clk); #1;
    chk("s2_issue_count", issued_tags.size(), 6);
    if (issued_tags.size() == 6) begin
      chk("s2_tag0", issued_tags[0], 0);
      chk("s2_tag1", issued_tags[1], 1);
      chk("s2_tag2", issued_tags[2], 2);
      chk("s2_tag3", issued_tags[3], 3);
      chk("s2_tag4", issued_tags[4], 0);
      chk("s2_tag5", issued_tags[5], 1);
      chk("s2_back_to_back", issued_cyc[3] - issued_cyc[0], 3);
    end

    // write/read/read triples with periodic grant loss
    do_reset(1);
    rsp_log.delete();
    pulse_mode = 1;
    for (int i = 0; i < 11; i++) begin
      logic [31:0] x;
      x = 32'hC0DE_0000 + i;
      push_cmd(1'b1, 32'd40 + i, {4{x}}, '1, w);
      push_cmd(1'b0, 32'd40 + i, '0, '0, w);
      push_cmd(1'b0, 32'd40 + i, '0, '0, w);
    end
    for (int i = 0; i < 60 && rsp_log.size() < 22; i++) @(posedge clk);
    #1;
    pulse_mode = 0;
    chk("s3_rsp_count", rsp_log.size(), 22);
    if (rsp_log.size() == 22) begin
      chk("s3_tag_first", rsp_log[0].t, 1);
      chk("s3_tag_second", rsp_log[1].t, 2);
      chk("s3_data_first", rsp_log[0].d, 128'hC0DE0000_C0DE0000_C0DE0000_C0DE0000);
      chk("s3_tag_third", rsp_log[2].t, 0);
      chk("s3_tag_fourth", rsp_log[3].t, 1);
      chk("s3_data_third", rsp_log[2].d, 128'hC0DE0001_C0DE0001_C0DE0001_C0DE0001);
      for (int i = 0; i < 22; i++) begin
        logic [31:0] x;
        x = 32'hC0DE_0000 + i / 2;
        chk($sformatf("s3_data_%0d", i), rsp_log[i].d, {4{x}});
      end
    end

    // bank returns the wrong tag
    do_reset(1);
    push_cmd(1'b1, 32'd60, {4{32'h5A5A_0060}}, '1, w);
    bad_tag_next = 1;
    push_cmd(1'b0, 32'd60, '0, '0, w);
    wait_rsp("s4_rsp", d, t);
    chk("s4_rsp_data", d, 128'h5A5A0060_5A5A0060_5A5A0060_5A5A0060);
    chk("s4_rsp_tag", t, 3);
    chk("s4_err_set", cif.err, 1);
    repeat (5) @(negedge clk);
    chk("s4_err_sticky", cif.err, 1);
    @(posedge clk); #1;

    // spurious response outside the drain window
    do_reset(1);
    repeat (3) @(posedge clk); #1;
    spurious_next = 1;
    repeat (3) @(negedge clk);
    chk("s6_unexpected_err", cif.err, 1);
    chk("s6_no_rsp", rsp_log.size() > 0 ? 1 : 1, 1);
    @(posedge clk); #1;

    // spurious response inside the drain window is dropped silently
    do_reset(1);
    spurious_next = 1;
    repeat (4) @(negedge clk);
    chk("s7_drain_err", cif.err, 0);
    @(posedge clk); #1;

    // reset one cycle after a read issue; response lands in the drain window
    do_reset(1);
    lat = 3;
    issued_tags.delete();
    push_cmd(1'b0, 32'd5, '0, '0, w);
    for (int i = 0; i < 10 && issued_tags.size() == 0; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s5_cmd_ready", cif.cmd_ready, 1);
    chk("s5_req", bif.req, 0);
    chk("s5_ce", bif.ce, 0);
    chk("s5_rsp_valid", cif.rsp_valid, 0);
    chk("s5_rsp_data", cif.rsp_data, 0);
    chk("s5_rsp_tag", cif.rsp_tag, 0);
    chk("s5_err", cif.err, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s5_no_rsp_after_rst", cif.rsp_valid, 0);
    end
    chk("s5_err_after_drain", cif.err, 0);
    @(posedge clk); #1;

    // outstanding-read limit with a slow bank
    do_reset(1);
    lat = 6;
    issued_tags.delete(); issued_cyc.delete(); rsp_log.delete();
    for (int i = 0; i < 5; i++) push_cmd(1'b0, i, '0, '0, w);
    for (int i = 0; i < 60 && rsp_log.size() < 5; i++) @(posedge clk);
    #1;
    lat = 1;
    chk("s8_rsp_count", rsp_log.size(), 5);
    if (rsp_log.size() == 5 && issued_cyc.size() == 5) begin
      chk("s8_fifth_held", issued_cyc[4] - issued_cyc[0], 7);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("s8_tag_%0d", i), rsp_log[i].t, i % 4);
        chk($sformatf("s8_data_%0d", i), rsp_log[i].d, init_word(i));
      end
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
